// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store port: funct3 codes and FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_pkg;

    // RISC-V load/store funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RMW_RD = 3'd2;
    localparam logic [2:0] ST_STORE  = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD   = ST_LOAD,
        S_RMW_RD = ST_RMW_RD,
        S_STORE  = ST_STORE,
        S_RESP   = ST_RESP
    } lsu_state_e;

    // Loads accept LB/LH/LW/LBU/LHU, stores accept SB/SH/SW only.
    function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (wr) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data, merges sub-word store data into a word.
// Latency: purely combinational.
// Backpressure: none.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed lane and extend according to funct3
    always_comb begin
        byte_v      = word_i[{addr_lo_i, 3'b000} +: 8];
        half_v      = word_i[{addr_lo_i[1], 4'b0000} +: 16];
        load_data_o = word_i;
        case (funct3_i)
            F3_LB:   load_data_o = {{24{byte_v[7]}}, byte_v};
            F3_LH:   load_data_o = {{16{half_v[15]}}, half_v};
            F3_LBU:  load_data_o = {24'd0, byte_v};
            F3_LHU:  load_data_o = {16'd0, half_v};
            default: load_data_o = word_i;
        endcase
    end

    // Merge the low byte/halfword of the store data into the read word
    always_comb begin
        store_word_o = word_i;
        case (funct3_i)
            F3_SB:   store_word_o[{addr_lo_i, 3'b000} +: 8]    = wdata_i[7:0];
            F3_SH:   store_word_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: store_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store port onto a word-only memory; sub-word stores via read-modify-write. Macro: LSU_MISALIGN_TRAP_EN.
// Latency: fault 1, load/SW 2, SB/SH 3 cycles from accept to rsp_valid.
// Backpressure: one request in flight; req_ready only in IDLE; responses cannot be stalled.
module lsu_mem_port
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    // Holds raw store data, replaced by the merged word during RMW_RD
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic [31:0] load_data;
    logic [31:0] store_word;
    logic [31:0] acc_addr;
    logic        acc_fault;

    lsu_lane_align u_align (
        .word_i       (mem_read_data),
        .addr_lo_i    (addr_q[1:0]),
        .funct3_i     (funct3_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    // Decode the incoming request: fault condition and effective address
    always_comb begin
        acc_addr = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        acc_fault = !f3_legal(req_write, req_funct3) ||
                    ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        acc_fault = !f3_legal(req_write, req_funct3);
        // Force the address down to the access size; halfword and word only
        if (req_funct3[1:0] == 2'b01) begin
            acc_addr[0] = 1'b0;
        end else if (req_funct3[1:0] == 2'b10) begin
            acc_addr[1:0] = 2'b00;
        end
`endif
    end

    // Next-state logic; rsp_rdata/rsp_fault only change on entry to RESP
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = acc_addr;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    if (acc_fault) begin
                        rdata_d = 32'd0;
                        fault_d = 1'b1;
                        state_d = S_RESP;
                    end else if (!req_write) begin
                        state_d = S_LOAD;
                    end else if (req_funct3 == F3_SW) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = load_data;
                fault_d = 1'b0;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                wdata_d = store_word;
                state_d = S_STORE;
            end
            S_STORE: begin
                rdata_d = 32'd0;
                fault_d = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    // Strobes decode from state; write gated by reset so a reset cycle never writes
    assign req_ready      = (state_q == S_IDLE);
    assign rsp_valid      = (state_q == S_RESP);
    assign rsp_rdata      = rdata_q;
    assign rsp_fault      = fault_q;
    assign mem_read       = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    assign mem_write      = (state_q == S_STORE) && !rst;
    assign mem_address    = {addr_q[31:2], 2'b00};
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: scoreboard of expected responses from a reference model.
// Latency: n/a (testbench).
// Backpressure: stimulus holds req_valid until accepted.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    lsu_mem_port dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_fault      (rsp_fault),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Word-wide data memory, indexed by address bits [9:2]
    logic [31:0] mem [0:255];
    assign mem_read_data = mem[mem_address[9:2]];
    always @(posedge clk) if (mem_write) mem[mem_address[9:2]] <= mem_write_data;

    // Reference memory image kept by the model
    logic [31:0] ref_mem [0:255];

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
        logic [3:0]  lat;
        logic [3:0]  nrd;
        logic [3:0]  nwr;
        logic [31:0] maddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && req_valid && req_ready) acc_cyc <= cyc;
    end

    // Monitor: strobe checks and response scoreboard
    always @(negedge clk) begin
        if (rst) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_read || mem_write)
                chk("strobe_exclusive", {31'd0, mem_read && mem_write}, 32'd0);
            if (mem_read) begin
                rd_cnt++;
                if (q.size() != 0) chk("read_addr", mem_address, q[0].maddr);
            end
            if (mem_write) begin
                wr_cnt++;
                if (q.size() != 0) begin
                    chk("write_addr", mem_address, q[0].maddr);
                    chk("write_data", mem_write_data, q[0].wdata);
                end else begin
                    fail_now("unexpected_mem_write");
                end
            end
            if (rsp_valid) begin
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, e.fault});
                    chk("latency", 32'(cyc - acc_cyc), {28'd0, e.lat});
                    chk("read_strobes", 32'(rd_cnt), {28'd0, e.nrd});
                    chk("write_strobes", 32'(wr_cnt), {28'd0, e.nwr});
                end else begin
                    fail_now("unexpected_rsp_valid");
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // Reference model: computes the response from the ISA rules and updates ref_mem
    task automatic predict(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output exp_t e);
        logic        legal;
        logic        fault;
        int          size;
        logic [31:0] a, w, val, mask, nw;
        int          sh;
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        a     = addr;
`ifdef LSU_MISALIGN_TRAP_EN
        fault = !legal || ((addr % size) != 0);
`else
        fault = !legal;
        a     = addr - (addr % size);
`endif
        w     = ref_mem[a[9:2]];
        sh    = 8 * int'(a[1:0]);
        e       = '0;
        e.maddr = {addr[31:2], 2'b00};
        if (fault) begin
            e.fault = 1'b1;
            e.lat   = 4'd1;
        end else if (!wr) begin
            val = w >> sh;
            case (f3)
                3'd0:    e.rdata = $signed(val[7:0]);
                3'd1:    e.rdata = $signed(val[15:0]);
                3'd4:    e.rdata = val & 32'hFF;
                3'd5:    e.rdata = val & 32'hFFFF;
                default: e.rdata = val;
            endcase
            e.lat = 4'd2;
            e.nrd = 4'd1;
        end else begin
            mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
            mask = mask << sh;
            nw   = (w & ~mask) | ((wdata << sh) & mask);
            ref_mem[a[9:2]] = nw;
            e.wdata = nw;
            e.lat   = (size == 4) ? 4'd2 : 4'd3;
            e.nrd   = (size == 4) ? 4'd0 : 4'd1;
            e.nwr   = 4'd1;
        end
    endtask

    // Driver: call at a negedge; returns at the negedge after acceptance
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        logic rdy;
        int   guard;
        exp_t e;
        guard      = 0;
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        forever begin
            rdy = req_ready;
            @(posedge clk);
            if (rdy) break;
            @(negedge clk);
            guard++;
            if (guard > 50) break;
        end
        if (guard > 50) begin
            fail_now("accept_timeout");
            req_valid = 1'b0;
        end else begin
            predict(wr, f3, addr, wdata, e);
            q.push_back(e);
            #1 req_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q.size() != 0 || !req_ready) && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) fail_now("drain_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom();
            ref_mem[i] = mem[i];
        end
        mem[8'h40]     = 32'h8899AABB;
        ref_mem[8'h40] = 32'h8899AABB;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        chk("reset_mem_read", {31'd0, mem_read}, 32'd0);
        chk("reset_mem_write", {31'd0, mem_write}, 32'd0);
        chk("reset_mem_address", mem_address, 32'd0);
        chk("reset_mem_wdata", mem_write_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed loads from the preloaded word
        issue(1'b0, 3'b000, 32'h101, 32'd0); drain();
        chk("lb_0x101", rsp_rdata, 32'hFFFF_FFAA);
        issue(1'b0, 3'b100, 32'h103, 32'd0); drain();
        chk("lbu_0x103", rsp_rdata, 32'h0000_0088);
        issue(1'b0, 3'b101, 32'h102, 32'd0); drain();
        chk("lhu_0x102", rsp_rdata, 32'h0000_8899);

        // Byte store by read-modify-write, then read back
        issue(1'b1, 3'b000, 32'h102, 32'h1234_5677); drain();
        issue(1'b0, 3'b010, 32'h100, 32'd0); drain();
        chk("lw_after_sb", rsp_rdata, 32'h8877_AABB);

        // Back-to-back SW then LW
        issue(1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF);
        a1 = acc_cyc;
        issue(1'b0, 3'b010, 32'h200, 32'd0);
        a2 = acc_cyc;
        drain();
        chk("lw_after_sw", rsp_rdata, 32'hDEAD_BEEF);
        chk("b2b_spacing", 32'(a2 - a1), 32'd3);

        // Misaligned halfword load
        issue(1'b0, 3'b001, 32'h101, 32'd0); drain();
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lh_misaligned_fault", {31'd0, rsp_fault}, 32'd1);
`else
        chk("lh_misaligned_data", rsp_rdata, 32'hFFFF_AABB);
`endif

        // Illegal funct3
        issue(1'b0, 3'b011, 32'h100, 32'd0); drain();
        chk("illegal_f3_fault", {31'd0, rsp_fault}, 32'd1);
        chk("illegal_f3_rdata", rsp_rdata, 32'd0);

        // Reset during RMW_RD of SH 0x100: request is dropped
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h100;
        req_wdata  = 32'h0000_5A5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_rd_mem_read", {31'd0, mem_read}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        chk("word_after_reset", mem[8'h40], ref_mem[8'h40]);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ad;
            ad = $urandom();
            if ($urandom_range(0, 1) == 0) ad[31:10] = '0;
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ad, $urandom());
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
            chk("memory_image_mismatches", 32'(bad), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
